// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, buffered word to decode.
// Optional misaligned-redirect trap via FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                misalign_fault,
`endif
    input  logic                br_taken,
    input  logic [PC_WIDTH-1:0] br_pc,
    input  logic [63:0]         br_imm
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        , HALT
`endif
    } state_e;

    localparam logic [PC_WIDTH-1:0] LOW2 = PC_WIDTH'(3);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                squash_q, squash_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] ipc_q, ipc_d;
    logic [PC_WIDTH-1:0] sum;
    logic [PC_WIDTH-1:0] target;

    assign sum = br_pc + br_imm[PC_WIDTH-1:0];

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
    logic misaligned;

    assign target     = sum;
    assign misaligned = |target[1:0];
`else
    assign target = sum & ~LOW2;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d  = fault_q;
`endif
        if (br_taken) begin
            case (state_q)
                IDLE, REQ: begin
                    pc_d = target;
                    if (state_q == REQ && imem_req_ready) begin
                        // old-address response is already in flight
                        state_d  = WAIT;
                        squash_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
                WAIT: begin
                    pc_d = target;
                    if (imem_rsp_valid) begin
                        state_d  = REQ;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end
                HOLD: begin
                    pc_d    = target;
                    state_d = REQ;
                end
                default: ;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned && state_q != HALT) begin
                state_d  = HALT;
                squash_d = 1'b0;
                fault_d  = 1'b1;
            end
`endif
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_req_ready) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = REQ;
                        end else begin
                            instr_d = imem_rsp_data;
                            ipc_d   = pc_q;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        pc_d    = pc_q + PC_WIDTH'(4);
                        state_d = REQ;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
            instr_q  <= '0;
            ipc_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q  <= fault_d;
`endif
        end
    end

    assign imem_req_valid = (state_q == REQ);
    assign imem_addr      = pc_q;
    assign instr_valid    = (state_q == HOLD);
    assign instr          = instr_q;
    assign instr_pc       = ipc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_fault = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a pc scoreboard queue.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        br_taken = 1'b0;
    logic [63:0] br_pc = '0;
    logic [63:0] br_imm = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int prev_acc = 0;
    int last_acc = 0;
    logic [63:0] sb_q[$];

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misalign_fault (misalign_fault),
`endif
        .br_taken       (br_taken),
        .br_pc          (br_pc),
        .br_imm         (br_imm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_valid && n < 20) begin
            tick();
            n++;
        end
        chk("req_timeout", 64'(imem_req_valid), 64'd1);
    endtask

    task automatic wait_iv();
        int n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk("iv_timeout", 64'(instr_valid), 64'd1);
    endtask

    // Zero-wait memory unless acc_dly/hold stretch the handshakes.
    task automatic do_fetch(input logic [63:0] ea, input int acc_dly,
                            input int hold);
        logic [63:0] p;
        wait_req();
        chk("req_addr", imem_addr, ea);
        for (int i = 0; i < acc_dly; i++) begin
            tick();
            chk("addr_stable", imem_addr, ea);
            chk("req_held", 64'(imem_req_valid), 64'd1);
        end
        imem_req_ready = 1'b1;
        sb_q.push_back(ea);
        prev_acc = last_acc;
        last_acc = cyc;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data_of(ea);
        tick();
        imem_rsp_valid = 1'b0;
        wait_iv();
        p = sb_q.pop_front();
        chk("instr_pc", instr_pc, p);
        chk("instr", 64'(instr), 64'(data_of(p)));
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_instr", 64'(instr), 64'(data_of(p)));
            chk("hold_pc", instr_pc, p);
            chk("hold_noreq", 64'(imem_req_valid), 64'd0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_req", 64'(imem_req_valid), 64'd0);
        chk("rst_iv", 64'(instr_valid), 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_ipc", instr_pc, 64'd0);
        tick();
        chk("first_req", 64'(imem_req_valid), 64'd1);

        // 1: sequential fetch and throughput
        do_fetch(64'h0, 0, 0);
        do_fetch(64'h4, 0, 0);
        do_fetch(64'h8, 0, 0);
        chk("thruput", 64'(last_acc - prev_acc), 64'd3);

        // 2: decode stall, then slow accept
        do_fetch(64'hC, 0, 10);
        do_fetch(64'h10, 3, 0);

        // 3: redirect in WAIT, late response dropped
        wait_req();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        br_taken = 1'b1;
        br_pc    = 64'h100;
        br_imm   = -64'sd8;
        tick();
        br_taken = 1'b0;
        chk("w_noreq", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        chk("w_noiv", 64'(instr_valid), 64'd0);
        chk("w_req", 64'(imem_req_valid), 64'd1);
        chk("w_tgt", imem_addr, 64'hF8);
        do_fetch(64'hF8, 0, 0);

        // redirect coinciding with request accept
        imem_req_ready = 1'b1;
        br_taken = 1'b1;
        br_pc    = 64'h300;
        br_imm   = 64'h20;
        tick();
        imem_req_ready = 1'b0;
        br_taken = 1'b0;
        chk("ra_noreq", 64'(imem_req_valid), 64'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0001;
        tick();
        imem_rsp_valid = 1'b0;
        chk("ra_noiv", 64'(instr_valid), 64'd0);
        chk("ra_tgt", imem_addr, 64'h320);
        do_fetch(64'h320, 0, 0);

        // 4: redirect with same-cycle response
        wait_req();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0002;
        br_taken = 1'b1;
        br_pc    = 64'h200;
        br_imm   = 64'h40;
        tick();
        imem_rsp_valid = 1'b0;
        br_taken = 1'b0;
        chk("s_noiv", 64'(instr_valid), 64'd0);
        chk("s_req", 64'(imem_req_valid), 64'd1);
        chk("s_tgt", imem_addr, 64'h240);
        do_fetch(64'h240, 0, 0);

        // redirect while holding, with decode accepting
        wait_req();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data_of(64'h244);
        tick();
        imem_rsp_valid = 1'b0;
        chk("h_ipc", instr_pc, 64'h244);
        instr_ready = 1'b1;
        br_taken = 1'b1;
        br_pc    = 64'h400;
        br_imm   = -64'sd16;
        tick();
        instr_ready = 1'b0;
        br_taken = 1'b0;
        chk("h_noiv", 64'(instr_valid), 64'd0);
        chk("h_tgt", imem_addr, 64'h3F0);

        // 5: pc wrap, then reset in WAIT
        br_taken = 1'b1;
        br_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        br_imm   = 64'h0;
        tick();
        br_taken = 1'b0;
        do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        chk("wrap", imem_addr, 64'h0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("mr_req", 64'(imem_req_valid), 64'd0);
        chk("mr_iv", 64'(instr_valid), 64'd0);
        chk("mr_addr", imem_addr, 64'd0);
        chk("mr_instr", 64'(instr), 64'd0);
        chk("mr_ipc", instr_pc, 64'd0);
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0003;
        reset = 1'b0;
        tick();
        tick();
        imem_rsp_valid = 1'b0;
        chk("stray_iv", 64'(instr_valid), 64'd0);
        chk("stray_addr", imem_addr, 64'd0);
        do_fetch(64'h0, 0, 0);

        // 6: misaligned redirect target
        br_taken = 1'b1;
        br_pc    = 64'h10;
        br_imm   = 64'h2;
        tick();
        br_taken = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", 64'(misalign_fault), 64'd1);
        imem_rsp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_noreq", 64'(imem_req_valid), 64'd0);
            chk("halt_noiv", 64'(instr_valid), 64'd0);
        end
        imem_rsp_valid = 1'b0;
`else
        chk("mis_addr", imem_addr, 64'h10);
        do_fetch(64'h10, 0, 0);
`endif

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
